// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Holds the program counter, drives
//                the instruction ROM address, and captures the returned
//                instruction into the IF/ID pipeline register. It handles
//                stall, flush and branch/jump redirect, and counts the
//                instructions it delivers.
//
//  Ports
//    clk           in   1   rising-edge clock
//    rst           in   1   asynchronous, active-high reset
//    stall         in   1   hazard stall: hold PC and IF/ID
//    flush         in   1   kill the instruction being captured into IF/ID
//    redirect      in   1   taken branch/jump from a later stage
//    redirect_pc   in  32   redirect target address
//    pc            out 32   current fetch address (ROM uses pc[7:2])
//    inst_in       in  32   combinational ROM word for pc
//    id_inst       out 32   IF/ID instruction
//    id_pc         out 32   IF/ID address of id_inst
//    id_pc4        out 32   IF/ID id_pc + 4
//    id_valid      out  1   IF/ID holds a real instruction (0 = bubble)
//    fetch_count   out 32   instructions delivered with id_valid = 1
//    misalign_trap out  1   sticky misaligned-redirect flag
//
//  Parameters
//    RESET_PC      PC loaded on reset (must be word-aligned)
//
//  Build option
//    IF_MISALIGN_TRAP_EN  When defined, a redirect whose target has
//                         redirect_pc[1:0] != 0 enters a TRAP state that
//                         inserts bubbles until an aligned redirect arrives.
//                         When undefined, the low two target bits are
//                         dropped and misalign_trap is tied low.
//
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count,
    output logic        misalign_trap
);

    // ------------------------------------------------------------------------
    // State encoding. TRAP only exists when the misaligned-trap option is built.
    // ------------------------------------------------------------------------
`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    state_t r_state;

    // ------------------------------------------------------------------------
    // Next-address arithmetic. Both additions wrap modulo 2^32; the ROM
    // aliases addresses itself so no bound check is done here.
    // ------------------------------------------------------------------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    state_t      w_redir_state;

    assign w_pc_plus4 = pc + 32'd4;

    // The fetched target is always word-aligned; the dropped bits only
    // matter for trap detection.
    assign w_target   = {redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
    logic w_misaligned;

    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_redir_state = w_misaligned ? TRAP : RUN;
`else
    // Low target bits are intentionally discarded in this build.
    logic [1:0] w_unused_low_bits;

    assign w_unused_low_bits = redirect_pc[1:0];
    assign w_redir_state     = RUN;
    assign misalign_trap     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // PC, IF/ID register, delivery counter and state machine.
    //
    // IF/ID priority in RUN: redirect/flush (bubble) > stall (hold) > load.
    // PC priority in RUN:    redirect > stall (hold) > pc + 4.
    // A bubble clears id_inst and id_valid but keeps id_pc/id_pc4, so the
    // last real address stays visible for debug.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            pc            <= RESET_PC;
            id_inst       <= 32'd0;
            id_pc         <= 32'd0;
            id_pc4        <= 32'd0;
            id_valid      <= 1'b0;
            fetch_count   <= 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            case (r_state)
                // First cycle after reset: the ROM word for RESET_PC is not
                // delivered yet, so IF/ID gets a bubble and the PC holds
                // unless a redirect is already pending.
                BOOT: begin
                    id_inst  <= 32'd0;
                    id_valid <= 1'b0;
                    if (redirect) begin
                        pc      <= w_target;
                        r_state <= w_redir_state;
`ifdef IF_MISALIGN_TRAP_EN
                        misalign_trap <= w_misaligned;
`endif
                    end else begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (redirect) begin
                        // Redirect wins over stall for both PC and IF/ID.
                        id_inst  <= 32'd0;
                        id_valid <= 1'b0;
                        pc       <= w_target;
                        r_state  <= w_redir_state;
`ifdef IF_MISALIGN_TRAP_EN
                        misalign_trap <= w_misaligned;
`endif
                    end else if (flush) begin
                        // Flush kills the capture; the PC still obeys stall.
                        id_inst  <= 32'd0;
                        id_valid <= 1'b0;
                        if (!stall) begin
                            pc <= w_pc_plus4;
                        end
                    end else if (!stall) begin
                        id_inst     <= inst_in;
                        id_pc       <= pc;
                        id_pc4      <= w_pc_plus4;
                        id_valid    <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= w_pc_plus4;
                    end
                    // stall alone: everything holds
                end

`ifdef IF_MISALIGN_TRAP_EN
                // Parked after a misaligned redirect: bubbles only, PC holds,
                // stall/flush ignored. Any redirect reloads the PC; only an
                // aligned one returns to RUN and clears the flag.
                TRAP: begin
                    id_inst  <= 32'd0;
                    id_valid <= 1'b0;
                    if (redirect) begin
                        pc            <= w_target;
                        r_state       <= w_redir_state;
                        misalign_trap <= w_misaligned;
                    end
                end
`endif

                default: begin
                    r_state  <= BOOT;
                    id_inst  <= 32'd0;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
